fm_mon_arbiter: RTL

Round-robin arbiter that shares the single floating-monitor output link between `N_SRC` monitor sources (fm dummy blocks or real monitor taps). It grants one source at a time, forwards up to `MAX_BURST` consecutive words from it as a packet, and applies downstream backpressure to the granted source only. It sits between the per-source fm monitor outputs and the fm transport/spy-buffer input.

---
 rtl/fm_mon_arbiter_if.sv | 26 ++
 rtl/fm_mon_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fm_mon_arbiter_if.sv
// Bundle of source-side and monitor-link signals for fm_mon_arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface fm_mon_arbiter_if #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 32
);
    logic [N_SRC*DATA_WIDTH-1:0] src_data;
    logic [N_SRC-1:0]            src_vld;
    logic [N_SRC-1:0]            src_ready;
    logic [DATA_WIDTH-1:0]       mon_data;
    logic                        mon_vld;
    logic                        mon_ready;
    logic [3:0]                  grant_id;
    logic                        busy;
    logic [1:0]                  arb_state;

    modport master (
        input  src_data, src_vld, mon_ready,
        output src_ready, mon_data, mon_vld, grant_id, busy, arb_state
    );

    modport slave (
        output src_data, src_vld, mon_ready,
        input  src_ready, mon_data, mon_vld, grant_id, busy, arb_state
    );
endinterface

// File: rtl/fm_mon_arbiter.sv
// Round-robin arbiter packing N_SRC monitor sources onto one registered output link.
// Define FM_ARB_HEADER_EN to prefix every packet with a header word (0xA5, grant id, sequence).
module fm_mon_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 5
) (
    input  logic            clk,
    input  logic            rst,
    fm_mon_arbiter_if.master bus
);

    // Handshake: a word moves on a rising edge exactly when valid and its ready are
    // both high; a valid word is held unchanged until it is accepted.

    localparam logic [7:0] MAX_B    = 8'(MAX_BURST);
    localparam logic [3:0] LAST_RST = 4'(N_SRC - 1);

`ifdef FM_ARB_HEADER_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_BURST  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BURST  = 2'd2
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [3:0]            grant_q, grant_d;
    logic [3:0]            last_q, last_d;
    logic [7:0]            beat_q, beat_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;
`ifdef FM_ARB_HEADER_EN
    logic [7:0]            seq_q, seq_d;
    logic [DATA_WIDTH-1:0] hdr_word;
`endif

    logic                  out_free;
    logic                  g_vld;
    logic [DATA_WIDTH-1:0] g_word;
    logic                  hit;
    logic [3:0]            hit_id;
    logic [N_SRC-1:0]      ready;

    assign out_free = !vld_q || bus.mon_ready;

    always_comb begin : grant_mux
        g_vld  = 1'b0;
        g_word = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == 4'(i)) begin
                g_vld  = bus.src_vld[i];
                g_word = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Walk priorities from lowest to highest so the closest requester after last_q wins.
    always_comb begin : rr_search
        hit    = 1'b0;
        hit_id = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            for (int j = 0; j < N_SRC; j++) begin
                if (bus.src_vld[j] && (((int'(last_q) + k) % N_SRC) == j)) begin
                    hit    = 1'b1;
                    hit_id = 4'(j);
                end
            end
        end
    end

`ifdef FM_ARB_HEADER_EN
    always_comb begin : hdr_build
        hdr_word        = '0;
        hdr_word[23:16] = 8'hA5;
        hdr_word[15:8]  = {4'h0, grant_q};
        hdr_word[7:0]   = seq_q;
    end
`endif

    always_comb begin : fsm_next
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        data_d  = data_q;
        vld_d   = vld_q;
        ready   = '0;
`ifdef FM_ARB_HEADER_EN
        seq_d   = seq_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (out_free) begin
                    vld_d = 1'b0;
                end
                if (hit) begin
                    grant_d = hit_id;
                    beat_d  = '0;
`ifdef FM_ARB_HEADER_EN
                    state_d = S_HEADER;
`else
                    state_d = S_BURST;
`endif
                end
            end
`ifdef FM_ARB_HEADER_EN
            S_HEADER: begin
                if (out_free) begin
                    data_d  = hdr_word;
                    vld_d   = 1'b1;
                    seq_d   = seq_q + 8'd1;
                    state_d = S_BURST;
                end
            end
`endif
            S_BURST: begin
                if (out_free) begin
                    for (int j = 0; j < N_SRC; j++) begin
                        ready[j] = (grant_q == 4'(j));
                    end
                    if (g_vld) begin
                        data_d = g_word;
                        vld_d  = 1'b1;
                        beat_d = beat_q + 8'd1;
                        if (beat_q + 8'd1 == MAX_B) begin
                            last_d  = grant_q;
                            state_d = S_IDLE;
                        end
                    end else begin
                        // Source gap: close the packet rather than stall the link.
                        vld_d   = 1'b0;
                        last_d  = grant_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            beat_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
`ifdef FM_ARB_HEADER_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
`ifdef FM_ARB_HEADER_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign bus.src_ready = ready;
    assign bus.mon_data  = data_q;
    assign bus.mon_vld   = vld_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.arb_state = state_q;

endmodule
